bsg_manycore_io_arbiter: RTL and testbench
==========================================

BSG_MANYCORE_IO_ARBITER -- requirements
Module: bsg_manycore_io_arbiter

Interface
REQ-001 SHALL have parameter payload_width_p, default 64: request/response payload bits, excluding tag.
REQ-002 SHALL have parameter tag_width_p, default 5: tag bits carried by requests and echoed in responses; the arbiter overwrites the tag MSB.
REQ-003 SHALL have parameter max_out_p, default 8: maximum outstanding requests per requester.
REQ-004 SHALL have ports clk_i, in, 1: the single clock; reset_i, in, 1: asynchronous, active-high reset.
REQ-005 SHALL have ports req_v_i, in, [1:0]: per-requester request valid; req_data_i, in, [1:0][payload_width_p+tag_width_p-1:0]: requests, with the tag in the low bits; req_yumi_o, out, [1:0]: request consumed.
REQ-006 SHALL have ports link_req_v_o, out, 1; link_req_data_o, out, payload_width_p+tag_width_p; link_req_ready_i, in, 1: single outbound link (valid/ready).
REQ-007 SHALL have ports link_resp_v_i, in, 1; link_resp_data_i, in, payload_width_p+tag_width_p; link_resp_yumi_o, out, 1: inbound responses.
REQ-008 SHALL have ports resp_v_o, out, [1:0]; resp_data_o, out, payload_width_p+tag_width_p; resp_ready_i, in, [1:0]: per-requester responses.
REQ-009 SHALL have port out_count_o, out, [1:0][clog2(max_out_p+1)-1:0]: outstanding-request counters.

Function
REQ-010 SHALL register the outbound request in one output slot: link_req_v_o/link_req_data_o are flopped, giving 1-cycle latency from req_yumi_o to link_req_v_o.
REQ-011 SHALL load the slot when it is empty, or when link_req_ready_i is high in the same cycle it drains (full throughput, one request per cycle).
REQ-012 SHALL treat requester i as eligible only when req_v_i[i] is high and out_count_o[i] < max_out_p.
REQ-013 SHALL grant among eligible requesters round-robin: last-granted pointer last_r, initially 1, so requester 0 wins first; on a tie the non-last requester wins; last_r updates only on a grant.
REQ-014 SHALL assert req_yumi_o[i] only for the granted requester in a loading cycle; at most one bit is high per cycle.
REQ-015 SHALL forward the request unchanged, except that tag bit tag_width_p-1 is replaced by the requester index.
REQ-016 SHALL increment out_count_o[i] on req_yumi_o[i], and decrement it on a delivered response (resp_v_o[i] and resp_ready_i[i]); a simultaneous increment and decrement leaves it unchanged.
REQ-017 SHALL steer a response combinationally by tag bit tag_width_p-1: resp_v_o[idx]=link_resp_v_i, the other resp_v_o bit is 0, and link_resp_yumi_o=link_resp_v_i & resp_ready_i[idx].
REQ-018 SHALL drive resp_data_o equal to link_resp_data_i, with the tag MSB cleared to 0.
REQ-019 SHALL hold link_req_v_o and link_req_data_o stable while link_req_v_o is high and link_req_ready_i is low.
REQ-020 SHALL assert a simulation error on a response to a requester whose count is 0 (underflow), and SHALL NOT change the count in that case.
REQ-021 SHALL NOT let a requester at max_out_p block the other requester.

Reset
REQ-022 SHALL, while reset_i is asserted asynchronously, clear the slot valid, out_count_o to 0, and last_r to 1.
REQ-023 SHALL drive req_yumi_o=0 and link_req_v_o=0 during reset; the response path outputs follow their inputs and are don't-care.
REQ-024 SHALL discard a slot request pending at mid-operation reset; it is not replayed.

Structure
REQ-025 SHALL take its packet widths and the link struct from bsg_manycore_pkg; it adds no new package.
REQ-026 SHALL use one sub-module, bsg_round_robin_arb, for grant selection; the counters and slot are local.

Verification
REQ-027 SHALL cover: req_v_i=2'b11 continuously with link_req_ready_i=1 -> grants alternate 0,1,0,1, and link_req_v_o is high every cycle after the first.
REQ-028 SHALL cover: requester 0 issues 8 requests with no responses, max_out_p=8 -> 9th not granted, requester 1 still granted, out_count_o[0]=8.
REQ-029 SHALL cover: link_req_ready_i=0 for 5 cycles with a slot loaded -> data stable, req_yumi_o=0; ready=1 -> drains, next loads the same cycle.
REQ-030 SHALL cover: response with tag 5'b10011 -> resp_v_o=2'b10, resp_data_o tag 5'b00011; with resp_ready_i[1]=0 -> link_resp_yumi_o=0 until ready.
REQ-031 SHALL cover: request grant and response delivery for requester 0 in the same cycle at count 3 -> count stays 3.
REQ-032 SHALL cover: reset asserted asynchronously mid-transfer (count=4, slot full) -> link_req_v_o=0 and counts 0 before the next clock edge; requester 0 granted first after release.

Source files
------------

// File: rtl/bsg_manycore_pkg.sv
// Shared manycore link widths, defaults and small helpers used by the IO arbiter.
package bsg_manycore_pkg;

    localparam int payload_width_gp = 64;
    localparam int tag_width_gp     = 5;
    localparam int max_out_gp       = 8;
    localparam int num_req_gp       = 2;

    // Link packet at the default widths: tag lives in the low bits of data.
    typedef struct packed {
        logic                                   v;
        logic [payload_width_gp+tag_width_gp-1:0] data;
    } link_packet_s;

    function automatic logic other_req(input logic idx);
        return ~idx;
    endfunction

endpackage

// File: rtl/bsg_round_robin_arb.sv
// Two-way round-robin grant selection; the requester that was not granted last wins a tie.
module bsg_round_robin_arb
    import bsg_manycore_pkg::*;
(
    input  logic [1:0] reqs,
    input  logic       last,
    output logic [1:0] grant,
    output logic       grant_idx
);

    always_comb begin
        grant_idx = 1'b0;
        if (reqs == 2'b11) begin
            grant_idx = other_req(last);
        end else begin
            grant_idx = reqs[1];
        end
        grant = {reqs[1] & grant_idx, reqs[0] & ~grant_idx};
    end

endmodule

// File: rtl/bsg_manycore_io_arbiter.sv
// Arbitrates two requesters onto one registered outbound link and steers
// responses back by the tag MSB, tracking outstanding requests per requester.
module bsg_manycore_io_arbiter
    import bsg_manycore_pkg::*;
#(
    parameter int payload_width_p = payload_width_gp,
    parameter int tag_width_p     = tag_width_gp,
    parameter int max_out_p       = max_out_gp
) (
    input  logic                                             clk_i,
    input  logic                                             reset_i,

    input  logic [1:0]                                       req_v_i,
    input  logic [1:0][payload_width_p+tag_width_p-1:0]      req_data_i,
    output logic [1:0]                                       req_yumi_o,

    output logic                                             link_req_v_o,
    output logic [payload_width_p+tag_width_p-1:0]           link_req_data_o,
    input  logic                                             link_req_ready_i,

    input  logic                                             link_resp_v_i,
    input  logic [payload_width_p+tag_width_p-1:0]           link_resp_data_i,
    output logic                                             link_resp_yumi_o,

    output logic [1:0]                                       resp_v_o,
    output logic [payload_width_p+tag_width_p-1:0]           resp_data_o,
    input  logic [1:0]                                       resp_ready_i,

    output logic [1:0][$clog2(max_out_p+1)-1:0]              out_count_o
);

    localparam int data_width_lp  = payload_width_p + tag_width_p;
    localparam int count_width_lp = $clog2(max_out_p + 1);
    localparam logic [count_width_lp-1:0] max_count_lp = count_width_lp'(max_out_p);

    logic                                  slot_v_p1;
    logic [data_width_lp-1:0]              slot_data_p1;
    logic                                  last_r;
    logic [1:0][count_width_lp-1:0]        count_r;

    logic [1:0]                            eligible;
    logic [1:0]                            grant;
    logic                                  grant_idx;
    logic                                  load;
    logic [data_width_lp-1:0]              fwd_data;
    logic                                  resp_idx;
    logic [1:0]                            delivered;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            eligible[i] = req_v_i[i] && (count_r[i] < max_count_lp);
        end
    end

    bsg_round_robin_arb arb (
        .reqs      (eligible),
        .last      (last_r),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // The slot accepts a new request when empty or draining this cycle.
    assign load       = (~slot_v_p1 | link_req_ready_i) & ~reset_i;
    assign req_yumi_o = load ? grant : 2'b00;

    always_comb begin
        fwd_data                = req_data_i[grant_idx];
        fwd_data[tag_width_p-1] = grant_idx;
    end

    assign link_req_v_o    = slot_v_p1;
    assign link_req_data_o = slot_data_p1;

    always_comb begin
        resp_idx                   = link_resp_data_i[tag_width_p-1];
        resp_v_o                   = 2'b00;
        resp_v_o[resp_idx]         = link_resp_v_i;
        link_resp_yumi_o           = link_resp_v_i & resp_ready_i[resp_idx];
        resp_data_o                = link_resp_data_i;
        resp_data_o[tag_width_p-1] = 1'b0;
        delivered                  = resp_v_o & resp_ready_i;
    end

    // Stage p1: outbound slot control, round-robin pointer and counters.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            slot_v_p1 <= 1'b0;
            last_r    <= 1'b1;
            count_r   <= '0;
        end else begin
            if (|req_yumi_o) begin
                slot_v_p1 <= 1'b1;
                last_r    <= grant_idx;
            end else if (link_req_ready_i) begin
                slot_v_p1 <= 1'b0;
            end
            for (int i = 0; i < 2; i++) begin
                if (req_yumi_o[i] && !(delivered[i] && count_r[i] != '0)) begin
                    count_r[i] <= count_r[i] + count_width_lp'(1);
                end else if (!req_yumi_o[i] && delivered[i] && count_r[i] != '0) begin
                    count_r[i] <= count_r[i] - count_width_lp'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (|req_yumi_o) begin
            slot_data_p1 <= fwd_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            for (int i = 0; i < 2; i++) begin
                assert (!(delivered[i] && count_r[i] == '0))
                    else $error("io_arbiter: response underflow on requester %0d", i);
            end
        end
    end

    assign out_count_o = count_r;

endmodule

// File: tb/tb_bsg_manycore_io_arbiter.sv
// Directed and randomized checks of bsg_manycore_io_arbiter against a cycle-level reference model.
module tb_bsg_manycore_io_arbiter;

    localparam int PW  = 64;
    localparam int TW  = 5;
    localparam int MAX = 8;
    localparam int W   = PW + TW;

    logic               clk = 1'b0;
    logic               reset_i;
    logic [1:0]         req_v_i;
    logic [1:0][W-1:0]  req_data_i;
    logic [1:0]         req_yumi_o;
    logic               link_req_v_o;
    logic [W-1:0]       link_req_data_o;
    logic               link_req_ready_i;
    logic               link_resp_v_i;
    logic [W-1:0]       link_resp_data_i;
    logic               link_resp_yumi_o;
    logic [1:0]         resp_v_o;
    logic [W-1:0]       resp_data_o;
    logic [1:0]         resp_ready_i;
    logic [1:0][3:0]    out_count_o;

    bsg_manycore_io_arbiter #(.payload_width_p(PW), .tag_width_p(TW), .max_out_p(MAX)) dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .req_v_i          (req_v_i),
        .req_data_i       (req_data_i),
        .req_yumi_o       (req_yumi_o),
        .link_req_v_o     (link_req_v_o),
        .link_req_data_o  (link_req_data_o),
        .link_req_ready_i (link_req_ready_i),
        .link_resp_v_i    (link_resp_v_i),
        .link_resp_data_i (link_resp_data_i),
        .link_resp_yumi_o (link_resp_yumi_o),
        .resp_v_o         (resp_v_o),
        .resp_data_o      (resp_data_o),
        .resp_ready_i     (resp_ready_i),
        .out_count_o      (out_count_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit           m_slot_v;
    logic [W-1:0] m_slot_data;
    int           m_cnt [2];
    int           m_last;

    // Observations captured at the last step's check point
    logic [1:0]   obs_yumi;
    logic         obs_lrv;
    logic [1:0]   obs_rv;
    logic         obs_lyumi;
    logic [W-1:0] obs_rdata;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        req_v_i          = 2'b00;
        req_data_i       = '0;
        link_req_ready_i = 1'b1;
        link_resp_v_i    = 1'b0;
        link_resp_data_i = '0;
        resp_ready_i     = 2'b00;
    endtask

    task automatic model_reset();
        m_slot_v = 1'b0;
        m_cnt[0] = 0;
        m_cnt[1] = 0;
        m_last   = 1;
    endtask

    // Called at posedge+1 with inputs already applied; checks, clocks, advances the model.
    task automatic step();
        int           g;
        int           ridx;
        bit           e0, e1, can_load, deliver;
        logic [1:0]   exp_yumi, exp_rv;
        logic [W-1:0] exp_rdata, nd;
        #2;
        can_load = !m_slot_v || link_req_ready_i;
        e0 = req_v_i[0] && (m_cnt[0] < MAX);
        e1 = req_v_i[1] && (m_cnt[1] < MAX);
        g = -1;
        if (can_load) begin
            if (e0 && e1) g = 1 - m_last;
            else if (e0)  g = 0;
            else if (e1)  g = 1;
        end
        exp_yumi = (g < 0) ? 2'b00 : ((g == 0) ? 2'b01 : 2'b10);
        ridx = int'(link_resp_data_i[TW-1]);
        exp_rv = link_resp_v_i ? ((ridx == 1) ? 2'b10 : 2'b01) : 2'b00;
        deliver = link_resp_v_i && resp_ready_i[ridx];
        exp_rdata = link_resp_data_i;
        exp_rdata[TW-1] = 1'b0;

        obs_yumi = req_yumi_o; obs_lrv = link_req_v_o; obs_rv = resp_v_o;
        obs_lyumi = link_resp_yumi_o; obs_rdata = resp_data_o;

        check("req_yumi", req_yumi_o, exp_yumi);
        check("link_req_v", link_req_v_o, m_slot_v);
        if (m_slot_v) check("link_req_data", link_req_data_o, m_slot_data);
        check("resp_v", resp_v_o, exp_rv);
        check("resp_data", resp_data_o, exp_rdata);
        check("link_resp_yumi", link_resp_yumi_o, deliver);
        check("count0", out_count_o[0], m_cnt[0]);
        check("count1", out_count_o[1], m_cnt[1]);

        if (deliver && m_cnt[ridx] > 0) m_cnt[ridx]--;
        if (g >= 0) begin
            nd = req_data_i[g];
            nd[TW-1] = g[0];
            m_slot_v = 1'b1;
            m_slot_data = nd;
            m_last = g;
            m_cnt[g]++;
        end else if (link_req_ready_i) begin
            m_slot_v = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        req_v_i = 2'b11;
        reset_i = 1'b1;
        #1;
        check("rst_link_req_v", link_req_v_o, 1'b0);
        check("rst_req_yumi", req_yumi_o, 2'b00);
        check("rst_counts", out_count_o, 8'h00);
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        idle();
        model_reset();
    endtask

    function automatic logic [W-1:0] rnd_data();
        return W'({$urandom, $urandom, $urandom});
    endfunction

    logic [W-1:0] d0, d1, exp_d;
    int           ri;

    initial begin
        reset_i = 1'b1;
        idle();
        req_v_i = 2'b11;
        #1;
        check("init_link_req_v", link_req_v_o, 1'b0);
        check("init_req_yumi", req_yumi_o, 2'b00);
        check("init_counts", out_count_o, 8'h00);
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        idle();
        model_reset();

        // Alternating grants under continuous contention
        req_v_i = 2'b11;
        for (int k = 0; k < 6; k++) begin
            req_data_i[0] = rnd_data();
            req_data_i[1] = rnd_data();
            step();
            check("alt_grant", obs_yumi, (k % 2 == 0) ? 2'b01 : 2'b10);
            if (k > 0) check("alt_link_v", obs_lrv, 1'b1);
        end

        // Requester 0 saturates at max_out_p; requester 1 still served
        do_reset();
        req_v_i = 2'b01;
        for (int k = 0; k < 8; k++) begin
            req_data_i[0] = rnd_data();
            step();
            check("sat_grant0", obs_yumi, 2'b01);
        end
        check("sat_count0", out_count_o[0], 4'd8);
        req_v_i = 2'b11;
        req_data_i[1] = rnd_data();
        step();
        check("sat_grant1", obs_yumi, 2'b10);
        req_v_i = 2'b01;
        step();
        check("sat_blocked", obs_yumi, 2'b00);

        // Backpressure holds the slot; drain and reload in the same cycle
        do_reset();
        d0 = rnd_data();
        d1 = rnd_data();
        req_v_i = 2'b01; req_data_i[0] = d0; link_req_ready_i = 1'b0;
        step();
        check("bp_first_load", obs_yumi, 2'b01);
        exp_d = d0;
        exp_d[TW-1] = 1'b0;
        req_v_i = 2'b11; req_data_i[1] = d1;
        for (int k = 0; k < 5; k++) begin
            step();
            check("bp_yumi", obs_yumi, 2'b00);
            check("bp_data", link_req_data_o, exp_d);
        end
        link_req_ready_i = 1'b1;
        req_v_i = 2'b10;
        step();
        check("bp_reload", obs_yumi, 2'b10);
        exp_d = d1;
        exp_d[TW-1] = 1'b1;
        check("bp_new_data", link_req_data_o, exp_d);

        // Response steering by tag MSB with per-requester ready
        do_reset();
        req_v_i = 2'b10; req_data_i[1] = rnd_data();
        step();
        req_v_i = 2'b00;
        link_resp_v_i = 1'b1;
        link_resp_data_i = {64'hDEAD_BEEF_0123_4567, 5'b10011};
        resp_ready_i = 2'b01;
        for (int k = 0; k < 2; k++) begin
            step();
            check("resp_steer", obs_rv, 2'b10);
            check("resp_tag", obs_rdata[TW-1:0], 5'b00011);
            check("resp_wait", obs_lyumi, 1'b0);
        end
        resp_ready_i = 2'b11;
        step();
        check("resp_accept", obs_lyumi, 1'b1);
        check("resp_count1", out_count_o[1], 4'd0);
        idle();

        // Grant and response for requester 0 in one cycle
        do_reset();
        req_v_i = 2'b01;
        for (int k = 0; k < 3; k++) begin
            req_data_i[0] = rnd_data();
            step();
        end
        link_resp_v_i = 1'b1;
        link_resp_data_i = rnd_data();
        link_resp_data_i[TW-1] = 1'b0;
        resp_ready_i = 2'b01;
        step();
        check("same_cycle_grant", obs_yumi, 2'b01);
        check("same_cycle_count", out_count_o[0], 4'd3);
        idle();

        // Randomized traffic
        do_reset();
        for (int k = 0; k < 400; k++) begin
            req_v_i          = 2'($urandom);
            req_data_i[0]    = rnd_data();
            req_data_i[1]    = rnd_data();
            link_req_ready_i = ($urandom_range(0, 3) != 0);
            resp_ready_i     = 2'($urandom);
            ri               = int'($urandom_range(0, 1));
            link_resp_data_i = rnd_data();
            link_resp_data_i[TW-1] = ri[0];
            link_resp_v_i    = (m_cnt[ri] > 0) && ($urandom_range(0, 2) != 0);
            step();
        end

        // Asynchronous reset mid-transfer
        do_reset();
        req_v_i = 2'b01;
        for (int k = 0; k < 4; k++) begin
            req_data_i[0] = rnd_data();
            step();
        end
        req_v_i = 2'b00;
        link_req_ready_i = 1'b0;
        #2;
        check("pre_rst_slot", link_req_v_o, 1'b1);
        check("pre_rst_count", out_count_o[0], 4'd4);
        reset_i = 1'b1;
        #1;
        check("async_rst_slot", link_req_v_o, 1'b0);
        check("async_rst_counts", out_count_o, 8'h00);
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        idle();
        model_reset();
        req_v_i = 2'b11;
        req_data_i[0] = rnd_data();
        req_data_i[1] = rnd_data();
        step();
        check("post_rst_grant", obs_yumi, 2'b01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
